// File: rtl/mpu_pkg.sv
// ============================================================================
// Module : mpu_pkg
// Brief  : Shared widths and state encoding for the MPU store path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpu_pkg;

  localparam int FP              = 32;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int MATRIX_REG_SIZE = 3;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_READ    = 3'd1,
    SEQ_CAPTURE = 3'd2,
    SEQ_SEND    = 3'd3,
    SEQ_DONE    = 3'd4
  } store_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mpu_index_counter.sv
// ============================================================================
// Module : mpu_index_counter
// Brief  : Row-major (i, j) walker shared by the load and store paths.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_index_counter #(
  parameter int I_W = 3,
  parameter int J_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  input  logic [J_W-1:0] n_size,
  output logic [I_W-1:0] i_idx,
  output logic [J_W-1:0] j_idx
);

  localparam logic [I_W-1:0] c_ONE_I = I_W'(1);
  localparam logic [J_W-1:0] c_ONE_J = J_W'(1);

  logic [I_W-1:0] r_i;
  logic [J_W-1:0] r_j;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
    end else if (clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (advance) begin
      if (r_j == n_size - c_ONE_J) begin
        r_j <= '0;
        r_i <= r_i + c_ONE_I;
      end else begin
        r_j <= r_j + c_ONE_J;
      end
    end
  end

  assign i_idx = r_i;
  assign j_idx = r_j;

endmodule

`default_nettype wire

// File: rtl/mpu_store_sequencer.sv
// ============================================================================
// Module : mpu_store_sequencer
// Brief  : Walks one matrix register row-major and streams it to memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_store_sequencer
  import mpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_req_in,
  input  logic [MATRIX_REG_SIZE-1:0] store_addr_in,
  output logic                       busy_out,
  output logic                       store_done_out,
  output logic                       reg_store_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [MBITS:0]             reg_m_store_size_in,
  input  logic [NBITS:0]             reg_n_store_size_in,
  input  logic [FP-1:0]              reg_store_element_in,
  output logic                       mem_valid_out,
  input  logic                       mem_ready_in,
  output logic [FP-1:0]              mem_element_out,
  output logic [MBITS:0]             mem_i_out,
  output logic [NBITS:0]             mem_j_out,
  output logic [MBITS:0]             mem_m_out,
  output logic [NBITS:0]             mem_n_out,
  output logic                       mem_last_out
);

  localparam logic [MBITS:0] c_ONE_M = (MBITS+1)'(1);
  localparam logic [NBITS:0] c_ONE_N = (NBITS+1)'(1);

  store_seq_state_t r_state, w_next;

  logic [MATRIX_REG_SIZE-1:0] r_addr;
  logic [MBITS:0]             r_m_lim;
  logic [NBITS:0]             r_n_lim;
  logic                       r_first;
  logic                       r_busy, r_done, r_en, r_valid, r_last;
  logic [FP-1:0]              r_elem;
  logic [MBITS:0]             r_mem_i, r_mem_m;
  logic [NBITS:0]             r_mem_j, r_mem_n;

  logic                       w_clear, w_advance, w_zero;
  logic [MBITS:0]             w_m_lim, w_i;
  logic [NBITS:0]             w_n_lim, w_j;

  mpu_index_counter #(
    .I_W (MBITS+1),
    .J_W (NBITS+1)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .advance (w_advance),
    .n_size  (r_n_lim),
    .i_idx   (w_i),
    .j_idx   (w_j)
  );

  // Only the sizes seen on the first capture bound the walk.
  assign w_m_lim = r_first ? reg_m_store_size_in : r_m_lim;
  assign w_n_lim = r_first ? reg_n_store_size_in : r_n_lim;
  assign w_zero  = (w_m_lim == '0) || (w_n_lim == '0);

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (store_req_in) begin
          w_next  = SEQ_READ;
          w_clear = 1'b1;
        end
      end
      SEQ_READ:    w_next = SEQ_CAPTURE;
      SEQ_CAPTURE: w_next = w_zero ? SEQ_DONE : SEQ_SEND;
      SEQ_SEND: begin
        if (mem_ready_in) begin
          if (r_last) begin
            w_next = SEQ_DONE;
          end else begin
            w_next    = SEQ_READ;
            w_advance = 1'b1;
          end
        end
      end
      SEQ_DONE: w_next = SEQ_IDLE;
      default:  w_next = SEQ_IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEQ_IDLE;
      r_addr  <= '0;
      r_m_lim <= '0;
      r_n_lim <= '0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_elem  <= '0;
      r_mem_i <= '0;
      r_mem_j <= '0;
      r_mem_m <= '0;
      r_mem_n <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != SEQ_IDLE);
      r_done  <= (w_next == SEQ_DONE);
      r_en    <= (w_next == SEQ_READ);
      r_valid <= (w_next == SEQ_SEND);
      if (r_state == SEQ_IDLE && store_req_in) begin
        r_addr  <= store_addr_in;
        r_first <= 1'b1;
      end
      if (r_state == SEQ_CAPTURE) begin
        r_elem  <= reg_store_element_in;
        r_mem_i <= w_i;
        r_mem_j <= w_j;
        r_mem_m <= reg_m_store_size_in;
        r_mem_n <= reg_n_store_size_in;
        r_last  <= (w_i == w_m_lim - c_ONE_M) && (w_j == w_n_lim - c_ONE_N);
        if (r_first) begin
          r_m_lim <= reg_m_store_size_in;
          r_n_lim <= reg_n_store_size_in;
          r_first <= 1'b0;
        end
      end
    end
  end

  assign busy_out            = r_busy;
  assign store_done_out      = r_done;
  assign reg_store_en_out    = r_en;
  assign reg_store_addr_out  = r_addr;
  assign reg_i_store_loc_out = w_i;
  assign reg_j_store_loc_out = w_j;
  assign mem_valid_out       = r_valid;
  assign mem_element_out     = r_elem;
  assign mem_i_out           = r_mem_i;
  assign mem_j_out           = r_mem_j;
  assign mem_m_out           = r_mem_m;
  assign mem_n_out           = r_mem_n;
  assign mem_last_out        = r_last;

endmodule

`default_nettype wire

// File: tb/tb_mpu_store_sequencer.sv
// ============================================================================
// Module : tb_mpu_store_sequencer
// Brief  : Randomised register-file/memory environment with a row-major model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpu_store_sequencer;
  import mpu_pkg::*;

  localparam int IW   = MBITS + 1;
  localparam int JW   = NBITS + 1;
  localparam int AW   = MATRIX_REG_SIZE;
  localparam int NREG = 1 << AW;
  localparam int PW   = FP + 2*IW + 2*JW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic store_req_in = 1'b0;
  logic [AW-1:0] store_addr_in = '0;
  logic busy_out, store_done_out, reg_store_en_out;
  logic [AW-1:0] reg_store_addr_out;
  logic [IW-1:0] reg_i_store_loc_out, reg_m_store_size_in = '0;
  logic [JW-1:0] reg_j_store_loc_out, reg_n_store_size_in = '0;
  logic [FP-1:0] reg_store_element_in = '0;
  logic mem_valid_out, mem_ready_in = 1'b1, mem_last_out;
  logic [FP-1:0] mem_element_out;
  logic [IW-1:0] mem_i_out, mem_m_out;
  logic [JW-1:0] mem_j_out, mem_n_out;

  mpu_store_sequencer dut (
    .clk(clk), .rst(rst), .store_req_in(store_req_in), .store_addr_in(store_addr_in),
    .busy_out(busy_out), .store_done_out(store_done_out),
    .reg_store_en_out(reg_store_en_out), .reg_store_addr_out(reg_store_addr_out),
    .reg_i_store_loc_out(reg_i_store_loc_out), .reg_j_store_loc_out(reg_j_store_loc_out),
    .reg_m_store_size_in(reg_m_store_size_in), .reg_n_store_size_in(reg_n_store_size_in),
    .reg_store_element_in(reg_store_element_in),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .mem_element_out(mem_element_out), .mem_i_out(mem_i_out), .mem_j_out(mem_j_out),
    .mem_m_out(mem_m_out), .mem_n_out(mem_n_out), .mem_last_out(mem_last_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [FP-1:0] rf_data [NREG][8][8];
  logic [IW-1:0] rf_m [NREG];
  logic [JW-1:0] rf_n [NREG];

  wire [PW-1:0] cur_pack = {mem_element_out, mem_i_out, mem_j_out, mem_m_out, mem_n_out, mem_last_out};
  wire [FP+3*AW+40:0] all_out = {busy_out, store_done_out, reg_store_en_out, reg_store_addr_out,
                                 reg_i_store_loc_out, reg_j_store_loc_out, mem_valid_out, cur_pack};

  // Register file: data is only meaningful in the cycle after a read strobe.
  logic rd_pend = 1'b0;
  int rd_a, rd_i, rd_j;
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      reg_store_element_in = rf_data[rd_a][rd_i][rd_j];
      reg_m_store_size_in  = rf_m[rd_a];
      reg_n_store_size_in  = rf_n[rd_a];
    end else begin
      reg_store_element_in = $urandom;
      reg_m_store_size_in  = IW'($urandom);
      reg_n_store_size_in  = JW'($urandom);
    end
    rd_pend = reg_store_en_out;
    rd_a = int'(reg_store_addr_out);
    rd_i = int'(reg_i_store_loc_out);
    rd_j = int'(reg_j_store_loc_out);
  end

  // Memory-side monitor: handshakes, done pulses and hold-stability under stall.
  logic [PW-1:0] hs_q [$];
  logic [PW-1:0] exp_q [$];
  int hs_cyc [$];
  int done_q [$];
  int hold_err = 0;
  int busy_drop = 0;
  logic prev_hold = 1'b0;
  logic [PW-1:0] prev_pack = '0;
  int req_edge = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!mem_valid_out || cur_pack != prev_pack)) hold_err++;
      prev_hold = mem_valid_out && !mem_ready_in;
      prev_pack = cur_pack;
      if (mem_valid_out && mem_ready_in) begin
        hs_q.push_back(cur_pack);
        hs_cyc.push_back(cyc);
      end
      if (store_done_out) done_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    hs_q.delete(); hs_cyc.delete(); done_q.delete(); hold_err = 0; busy_drop = 0;
  endtask

  task automatic build_exp(input int a);
    exp_q.delete();
    for (int i = 0; i < int'(rf_m[a]); i++)
      for (int j = 0; j < int'(rf_n[a]); j++)
        exp_q.push_back({rf_data[a][i][j], IW'(i), JW'(j), rf_m[a], rf_n[a],
                         1'((i == int'(rf_m[a]) - 1) && (j == int'(rf_n[a]) - 1))});
  endtask

  task automatic start_req(input int a);
    @(posedge clk); #1;
    store_req_in = 1'b1; store_addr_in = AW'(a); req_edge = cyc + 1;
    @(posedge clk); #1;
    store_req_in = 1'b0; store_addr_in = AW'($urandom);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall (1,0) four cycles, 3: random ready and requests
  task automatic wait_done(input int mode);
    int n = 0;
    int stall = 0;
    int d0 = done_q.size();
    while (done_q.size() == d0 && n < 400) begin
      if (busy_out !== 1'b1) busy_drop++;
      case (mode)
        0: mem_ready_in = 1'b1;
        1: mem_ready_in = ($urandom_range(0, 9) < 6);
        2: begin
          if (mem_valid_out && mem_i_out == 1 && mem_j_out == 0 && stall < 4) begin
            mem_ready_in = 1'b0; stall++;
          end else mem_ready_in = 1'b1;
        end
        default: begin
          mem_ready_in  = 1'($urandom_range(0, 1));
          store_req_in  = 1'($urandom_range(0, 1));
          store_addr_in = AW'($urandom);
        end
      endcase
      @(posedge clk); #1; n++;
    end
    if (mode == 3) store_req_in = 1'b0;
    if (n >= 400) begin
      vectors++; miscompares++;
      $display("FAIL wait_done timeout: no store_done_out within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (all_out !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
  endtask

  task automatic test_2x2();
    clear_logs(); build_exp(1);
    start_req(1); wait_done(0);
    vectors++;
    if (hs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL 2x2_count: got %0d want %0d", hs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
      vectors++;
      if (hs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL 2x2_elem%0d: got %h want %h", k, hs_q[k], exp_q[k]);
      end
      if (k > 0) begin
        vectors++;
        if (hs_cyc[k] - hs_cyc[k-1] != 3) begin
          miscompares++; $display("FAIL 2x2_spacing%0d: got %0d want 3", k, hs_cyc[k] - hs_cyc[k-1]);
        end
      end
    end
    if (hs_q.size() > 0 && done_q.size() > 0) begin
      vectors++;
      if (hs_cyc[0] != req_edge + 2) begin
        miscompares++; $display("FAIL 2x2_first_valid: got %0d want %0d", hs_cyc[0], req_edge + 2);
      end
      vectors++;
      if (done_q[0] != hs_cyc[hs_cyc.size()-1] + 1) begin
        miscompares++; $display("FAIL 2x2_done_time: got %0d want %0d", done_q[0], hs_cyc[hs_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_stall_3x1();
    clear_logs(); build_exp(2);
    start_req(2); wait_done(2);
    vectors++;
    if (hs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL stall_count: got %0d want %0d", hs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
      vectors++;
      if (hs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL stall_elem%0d: got %h want %h", k, hs_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_err);
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != req_edge + 13) begin
      miscompares++; $display("FAIL stall_done_time: got %0d want %0d",
                              done_q.size() > 0 ? done_q[0] : -1, req_edge + 13);
    end
  endtask

  task automatic test_zero(input int a);
    clear_logs();
    start_req(a); wait_done(0);
    vectors++;
    if (hs_q.size() != 0) begin
      miscompares++; $display("FAIL zero_%0d_count: got %0d want 0", a, hs_q.size());
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != req_edge + 2) begin
      miscompares++; $display("FAIL zero_%0d_done_time: got %0d want %0d", a,
                              done_q.size() > 0 ? done_q[0] : -1, req_edge + 2);
    end
  endtask

  task automatic test_mid_req();
    clear_logs(); build_exp(3);
    start_req(3); wait_done(3);
    vectors++;
    if (hs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL midreq_count: got %0d want %0d", hs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
      vectors++;
      if (hs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL midreq_elem%0d: got %h want %h", k, hs_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (busy_drop != 0) begin
      miscompares++; $display("FAIL midreq_busy: got %0d low cycles want 0", busy_drop);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0;
    clear_logs();
    start_req(1);
    while (!(mem_valid_out && mem_i_out == 0 && mem_j_out == 1) && n < 50) begin
      mem_ready_in = 1'b1; @(posedge clk); #1; n++;
    end
    mem_ready_in = 1'b0;
    vectors++;
    if (n >= 50) begin
      miscompares++; $display("FAIL rstmid_reach: element (0,1) not presented within %0d cycles", n);
    end
    d0 = done_q.size();
    rst = 1'b0; #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++; $display("FAIL rstmid_immediate: got %h want 0", all_out);
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (all_out !== '0) begin
        miscompares++; $display("FAIL rstmid_held: got %h want 0", all_out);
      end
    end
    rst = 1'b1; mem_ready_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (done_q.size() != d0 || busy_out !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_no_done: got %0d done pulses busy %b want 0 and 0",
                              done_q.size() - d0, busy_out);
    end
    clear_logs(); build_exp(1);
    start_req(1); wait_done(0);
    vectors++;
    if (hs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rstmid_restart_count: got %0d want %0d", hs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
      vectors++;
      if (hs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL rstmid_restart_elem%0d: got %h want %h", k, hs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int h_last;
    clear_logs();
    start_req(1);
    store_req_in = 1'b1; store_addr_in = AW'(3);
    wait_done(0);
    h_last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -100;
    vectors++;
    if (hs_q.size() != 4) begin
      miscompares++; $display("FAIL b2b_first_count: got %0d want 4", hs_q.size());
    end
    while (!reg_store_en_out && n < 10) begin
      @(posedge clk); #1; n++;
    end
    store_req_in = 1'b0;
    req_edge = cyc;
    vectors++;
    if (cyc != h_last + 3) begin
      miscompares++; $display("FAIL b2b_accept_time: got %0d want %0d", cyc, h_last + 3);
    end
    vectors++;
    if (reg_store_addr_out !== AW'(3)) begin
      miscompares++; $display("FAIL b2b_addr: got %0d want 3", reg_store_addr_out);
    end
    clear_logs(); build_exp(3);
    wait_done(0);
    vectors++;
    if (hs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_second_count: got %0d want %0d", hs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
      vectors++;
      if (hs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL b2b_second_elem%0d: got %h want %h", k, hs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    int pick [4] = '{3, 4, 6, 7};
    for (int t = 0; t < 6; t++) begin
      int a = pick[$urandom_range(0, 3)];
      clear_logs(); build_exp(a);
      start_req(a); wait_done(1);
      vectors++;
      if (hs_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", t, hs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
        vectors++;
        if (hs_q[k] !== exp_q[k]) begin
          miscompares++; $display("FAIL rand%0d_elem%0d: got %h want %h", t, k, hs_q[k], exp_q[k]);
        end
      end
      vectors++;
      if (hold_err != 0) begin
        miscompares++; $display("FAIL rand%0d_hold: got %0d unstable cycles want 0", t, hold_err);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < NREG; a++) begin
      rf_m[a] = IW'($urandom_range(1, 4));
      rf_n[a] = JW'($urandom_range(1, 4));
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          rf_data[a][i][j] = $urandom;
    end
    rf_m[0] = IW'(0); rf_n[0] = JW'(2);
    rf_m[1] = IW'(2); rf_n[1] = JW'(2);
    rf_m[2] = IW'(3); rf_n[2] = JW'(1);
    rf_m[5] = IW'(3); rf_n[5] = JW'(0);

    repeat (3) @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    test_2x2();
    test_stall_3x1();
    test_zero(0);
    test_zero(5);
    test_mid_req();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
